// File: rtl/pdp8_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// pdp8_mem_arb_pkg
// Shared definitions for the PDP-8 memory arbiter: FSM state encodings,
// DMA channel ids and default address/data widths.
// -----------------------------------------------------------------------------
package pdp8_mem_arb_pkg;

    localparam int AW_DEF           = 15;  // 32K words, IF/DF extended
    localparam int DW_DEF           = 12;  // PDP-8 word
    localparam int STARVE_LIMIT_DEF = 64;

    typedef enum logic [1:0] {
        MA_ST_IDLE  = 2'd0,
        MA_ST_ISSUE = 2'd1,
        MA_ST_DONE  = 2'd2
    } ma_state_t;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_id_t;

endpackage

// File: rtl/pdp8_mem_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// pdp8_rr_arb2
// Two-way round-robin picker. A lone requester is granted directly; when both
// request, ptr names the channel that wins (the one not served last).
// Ports:
//   req   in  [1:0]  request per channel (bit N = channel N)
//   ptr   in         preferred channel when both request
//   grant out [1:0]  one-hot grant, zero when nothing requests
// -----------------------------------------------------------------------------
module pdp8_rr_arb2
    import pdp8_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  ch_id_t     ptr,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: assign the default first so every path drives grant; a path
        // that skipped it would infer a latch.
        grant = req;
        if (req == 2'b11) begin
            grant = (ptr == CH1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/pdp8_mem_arb.sv
// -----------------------------------------------------------------------------
// pdp8_mem_arb
// Shares the single pdp8_ram port between the CPU and two data-break (DMA)
// channels. The CPU always wins and is never stalled; a DMA access is issued
// only in a clock where the CPU drives neither rd nor wr.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   cpu_addr/data_in/rd/wr     CPU access request
//   cpu_data_out               RAM read data to CPU (straight from RAM)
//   chN_read_req/write_req     DMA requests, held until chN_done
//   chN_ma, chN_in             DMA address / write data
//   chN_out                    DMA read data, registered on completion
//   chN_done                   one-clock completion pulse
//   ram_addr/data_in/rd/wr     to pdp8_ram
//   ram_data_out               from pdp8_ram, valid the clock after rd
//   dma_starved                DMA blocked STARVE_LIMIT consecutive clocks
// -----------------------------------------------------------------------------
module pdp8_mem_arb
    import pdp8_mem_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_data_in,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    output logic [DW-1:0] cpu_data_out,
    input  logic          ch0_read_req,
    input  logic          ch0_write_req,
    input  logic [AW-1:0] ch0_ma,
    input  logic [DW-1:0] ch0_in,
    output logic [DW-1:0] ch0_out,
    output logic          ch0_done,
    input  logic          ch1_read_req,
    input  logic          ch1_write_req,
    input  logic [AW-1:0] ch1_ma,
    input  logic [DW-1:0] ch1_in,
    output logic [DW-1:0] ch1_out,
    output logic          ch1_done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_rd,
    output logic          ram_wr,
    input  logic [DW-1:0] ram_data_out,
    output logic          dma_starved
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    ma_state_t     state, state_next;
    ch_id_t        rr_ptr;
    ch_id_t        lat_ch;
    logic          lat_wr;
    logic [AW-1:0] lat_ma;
    logic [DW-1:0] lat_in;
    logic [SW-1:0] starve_cnt;

    logic          cpu_busy;
    logic [1:0]    req;
    logic [1:0]    grant;
    ch_id_t        grant_ch;

    assign cpu_busy = cpu_rd | cpu_wr;
    assign req      = {ch1_read_req | ch1_write_req, ch0_read_req | ch0_write_req};
    assign grant_ch = grant[1] ? CH1 : CH0;

    pdp8_rr_arb2 u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            MA_ST_IDLE:  if (|req)     state_next = MA_ST_ISSUE;
            MA_ST_ISSUE: if (!cpu_busy) state_next = MA_ST_DONE;
            MA_ST_DONE:                state_next = MA_ST_IDLE;
            default:                   state_next = MA_ST_IDLE;
        endcase
    end

    // State register, request latches, starvation counter and read capture.
    // NOTE: lat_ma/lat_in/lat_wr carry no reset: they are only consumed in
    // ISSUE, which is always entered through a load in IDLE.
    always_ff @(posedge clk) begin
        lat_ch <= lat_ch;
        if (reset) begin
            state      <= MA_ST_IDLE;
            rr_ptr     <= CH0;
            starve_cnt <= '0;
            ch0_out    <= '0;
            ch1_out    <= '0;
            lat_ch     <= CH0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state <= state_next;
            unique case (state)
                MA_ST_IDLE: begin
                    if (|req) begin
                        lat_ch <= grant_ch;
                        // write wins when a channel raises both requests
                        lat_wr <= (grant_ch == CH1) ? ch1_write_req : ch0_write_req;
                        lat_ma <= (grant_ch == CH1) ? ch1_ma : ch0_ma;
                        lat_in <= (grant_ch == CH1) ? ch1_in : ch0_in;
                    end
                end
                MA_ST_ISSUE: begin
                    if (!cpu_busy) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                MA_ST_DONE: begin
                    // synchronous RAM: read data is valid in this clock
                    if (!lat_wr) begin
                        if (lat_ch == CH1) ch1_out <= ram_data_out;
                        else               ch0_out <= ram_data_out;
                    end
                    rr_ptr     <= (lat_ch == CH0) ? CH1 : CH0;
                    starve_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // RAM port mux: the CPU owns the port whenever it strobes.
    always_comb begin
        ram_addr    = '0;
        ram_data_in = '0;
        ram_rd      = 1'b0;
        ram_wr      = 1'b0;
        if (cpu_busy) begin
            ram_addr    = cpu_addr;
            ram_data_in = cpu_data_in;
            ram_rd      = cpu_rd;
            ram_wr      = cpu_wr;
        end else if (state == MA_ST_ISSUE) begin
            ram_addr    = lat_ma;
            ram_data_in = lat_in;
            ram_rd      = !lat_wr;
            ram_wr      = lat_wr;
        end
    end

    assign cpu_data_out = ram_data_out;
    assign ch0_done     = (state == MA_ST_DONE) && (lat_ch == CH0);
    assign ch1_done     = (state == MA_ST_DONE) && (lat_ch == CH1);
    assign dma_starved  = (starve_cnt == STARVE_MAX);

endmodule

// File: tb/tb_pdp8_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_pdp8_mem_arb
// Directed bench for pdp8_mem_arb with a behavioural synchronous RAM.
// Clock numbers in comments count from the first clock of each scenario.
// -----------------------------------------------------------------------------
module tb_pdp8_mem_arb;

    localparam int AW = 15;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data_in;
    logic          cpu_rd, cpu_wr;
    logic [DW-1:0] cpu_data_out;
    logic          ch0_read_req, ch0_write_req;
    logic [AW-1:0] ch0_ma;
    logic [DW-1:0] ch0_in, ch0_out;
    logic          ch0_done;
    logic          ch1_read_req, ch1_write_req;
    logic [AW-1:0] ch1_ma;
    logic [DW-1:0] ch1_in, ch1_out;
    logic          ch1_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in;
    logic          ram_rd, ram_wr;
    logic [DW-1:0] ram_data_out;
    logic          dma_starved;

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    // Synchronous RAM: write on the edge, read data valid the next clock.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_data_in;
        if (ram_rd) ram_data_out <= mem[ram_addr];
    end

    pdp8_mem_arb dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_addr      (cpu_addr),
        .cpu_data_in   (cpu_data_in),
        .cpu_rd        (cpu_rd),
        .cpu_wr        (cpu_wr),
        .cpu_data_out  (cpu_data_out),
        .ch0_read_req  (ch0_read_req),
        .ch0_write_req (ch0_write_req),
        .ch0_ma        (ch0_ma),
        .ch0_in        (ch0_in),
        .ch0_out       (ch0_out),
        .ch0_done      (ch0_done),
        .ch1_read_req  (ch1_read_req),
        .ch1_write_req (ch1_write_req),
        .ch1_ma        (ch1_ma),
        .ch1_in        (ch1_in),
        .ch1_out       (ch1_out),
        .ch1_done      (ch1_done),
        .ram_addr      (ram_addr),
        .ram_data_in   (ram_data_in),
        .ram_rd        (ram_rd),
        .ram_wr        (ram_wr),
        .ram_data_out  (ram_data_out),
        .dma_starved   (dma_starved)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[15'o00200] = 12'o1234;
        mem[15'o00300] = 12'o0011;
        mem[15'o00301] = 12'o0022;

        reset = 1'b1;
        cpu_addr = '0; cpu_data_in = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        ch0_read_req = 1'b0; ch0_write_req = 1'b0; ch0_ma = '0; ch0_in = '0;
        ch1_read_req = 1'b0; ch1_write_req = 1'b0; ch1_ma = '0; ch1_in = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_ram_rd",  ram_rd, 0);
        check("rst_ram_wr",  ram_wr, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ch0_done", ch0_done, 0);
        check("rst_ch1_done", ch1_done, 0);
        check("rst_ch0_out", ch0_out, 0);
        check("rst_ch1_out", ch1_out, 0);
        check("rst_starved", dma_starved, 0);

        // 1: ch0 read, CPU idle: done in clock 2
        ch0_ma = 15'o00200;
        ch0_read_req = 1'b1;
        tick();                                   // clock 1: ISSUE
        check("t1_ram_rd", ram_rd, 1);
        check("t1_ram_wr", ram_wr, 0);
        check("t1_ram_addr", ram_addr, 15'o00200);
        check("t1_done_early", ch0_done, 0);
        tick();                                   // clock 2: DONE
        check("t1_ch0_done", ch0_done, 1);
        check("t1_ch1_done", ch1_done, 0);
        ch0_read_req = 1'b0;
        tick();                                   // clock 3
        check("t1_done_drop", ch0_done, 0);
        check("t1_ch0_out", ch0_out, 12'o1234);

        // 2: ch1 write while the CPU reads for 10 clocks
        cpu_rd = 1'b1;
        cpu_addr = 15'o00200;
        ch1_ma = 15'o10017;
        ch1_in = 12'o7777;
        ch1_write_req = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("t2_no_dma_wr", ram_wr, 0);
            check("t2_cpu_data", cpu_data_out, 12'o1234);
        end
        tick();                                   // clock 10: CPU idle
        cpu_rd = 1'b0;
        #1;
        check("t2_ram_wr", ram_wr, 1);
        check("t2_ram_rd", ram_rd, 0);
        check("t2_ram_addr", ram_addr, 15'o10017);
        check("t2_ram_din", ram_data_in, 12'o7777);
        tick();                                   // clock 11: DONE
        check("t2_ch1_done", ch1_done, 1);
        ch1_write_req = 1'b0;
        tick();
        cpu_rd = 1'b1;
        cpu_addr = 15'o10017;
        tick();
        check("t2_readback", cpu_data_out, 12'o7777);
        cpu_addr = 15'o00200;
        tick();
        check("t2_cpu_intact", cpu_data_out, 12'o1234);
        cpu_rd = 1'b0;

        // 3: both channels held for 4 accesses -> ch0,ch1,ch0,ch1
        ch0_ma = 15'o00300;
        ch1_ma = 15'o00301;
        ch0_read_req = 1'b1;
        ch1_read_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();                               // DONE clock of access k
            check("t3_ch0_done", ch0_done, (k % 2 == 0) ? 1 : 0);
            check("t3_ch1_done", ch1_done, (k % 2 == 1) ? 1 : 0);
            if (k == 3) begin
                ch0_read_req = 1'b0;
                ch1_read_req = 1'b0;
            end
            tick();
        end
        check("t3_ch0_out", ch0_out, 12'o0011);
        check("t3_ch1_out", ch1_out, 12'o0022);

        // 4: CPU busy 70 clocks with ch0 pending -> starvation and saturation
        cpu_rd = 1'b1;
        cpu_addr = 15'o00200;
        ch0_ma = 15'o00300;
        ch0_read_req = 1'b1;
        for (int j = 1; j <= 69; j++) begin
            tick();
            if (j == 64) check("t4_not_starved_63", dma_starved, 0);
            if (j == 65) check("t4_starved_64", dma_starved, 1);
        end
        tick();                                   // clock 70: CPU idle
        cpu_rd = 1'b0;
        #1;
        check("t4_starved_sat", dma_starved, 1);
        check("t4_ram_rd", ram_rd, 1);
        check("t4_ram_addr", ram_addr, 15'o00300);
        tick();                                   // clock 71: DONE
        check("t4_ch0_done", ch0_done, 1);
        check("t4_starved_clr", dma_starved, 0);
        ch0_read_req = 1'b0;
        tick();
        check("t4_ch0_out", ch0_out, 12'o0011);
        check("t4_starved_low", dma_starved, 0);

        // 5: reset pulse in ISSUE aborts the access
        ch1_ma = 15'o00400;
        ch1_in = 12'o5555;
        ch1_write_req = 1'b1;
        cpu_rd = 1'b1;
        cpu_addr = 15'o00200;
        tick();                                   // clock 1: ISSUE, blocked
        check("t5_blocked", ram_wr, 0);
        reset = 1'b1;
        tick();                                   // clock 2: after reset
        reset = 1'b0;
        ch1_write_req = 1'b0;
        cpu_rd = 1'b0;
        #1;
        check("t5_ram_rd", ram_rd, 0);
        check("t5_ram_wr", ram_wr, 0);
        check("t5_ram_addr", ram_addr, 0);
        check("t5_ram_din", ram_data_in, 0);
        check("t5_ch0_done", ch0_done, 0);
        check("t5_ch1_done", ch1_done, 0);
        check("t5_ch0_out", ch0_out, 0);
        check("t5_ch1_out", ch1_out, 0);
        check("t5_starved", dma_starved, 0);
        tick();
        check("t5_no_late_done", ch1_done, 0);
        cpu_rd = 1'b1;
        cpu_addr = 15'o00400;
        tick();
        check("t5_no_write", cpu_data_out, 0);
        cpu_rd = 1'b0;

        // 6: read_req and write_req both high on ch1 -> write, single done
        ch1_ma = 15'o00500;
        ch1_in = 12'o0707;
        ch1_read_req = 1'b1;
        ch1_write_req = 1'b1;
        tick();                                   // clock 1: ISSUE
        check("t6_ram_wr", ram_wr, 1);
        check("t6_ram_rd", ram_rd, 0);
        check("t6_ram_addr", ram_addr, 15'o00500);
        check("t6_ram_din", ram_data_in, 12'o0707);
        tick();                                   // clock 2: DONE
        check("t6_ch1_done", ch1_done, 1);
        check("t6_ch0_done", ch0_done, 0);
        ch1_read_req = 1'b0;
        ch1_write_req = 1'b0;
        tick();
        check("t6_done_once", ch1_done, 0);
        check("t6_ch1_out", ch1_out, 0);
        cpu_rd = 1'b1;
        cpu_addr = 15'o00500;
        tick();
        check("t6_readback", cpu_data_out, 12'o0707);
        cpu_rd = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
